// File: rtl/gc_fifo.sv
// Gray-code FIFO pointer: binary count advanced by incr, presented as a registered Gray code.
// dataOut comes straight from a flop, so downstream synchronisers only ever see one bit move per step.
module gc_fifo #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             incr,
  output logic [WIDTH-1:0] dataOut
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Gray is re-derived from the next binary value every step, never from the old gray.
  always_comb begin
    bin_d  = bin_q;
    gray_d = gray_q;
    if (incr) begin
      bin_d  = bin_q + 1'b1;
      gray_d = bin_d ^ (bin_d >> 1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign dataOut = gray_q;

  a_gray_tracks_bin: assert property (@(posedge clk) disable iff (!rstN)
    gray2bin(gray_q) == bin_q);

endmodule

// File: tb/tb_gc_fifo.sv
// Randomised self-checking bench for gc_fifo: a plain modulo counter model drives the expected Gray values.
module tb_gc_fifo;
  localparam int W = 3;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         incr = 1'b0;
  logic [W-1:0] dataOut;

  int n_chk = 0;
  int n_fail = 0;
  int cnt = 0;
  logic [W-1:0] prev;

  gc_fifo #(.WIDTH(W)) dut (.clk(clk), .rstN(rstN), .incr(incr), .dataOut(dataOut));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] to_gray(input int n);
    logic [W-1:0] v;
    v = W'(n);
    return v ^ (v >> 1);
  endfunction

  // Decode by summing parity of all higher Gray bits, independent of the RTL helper.
  function automatic int from_gray(input logic [W-1:0] g);
    int r = 0;
    for (int i = 0; i < W; i++) begin
      int p = 0;
      for (int j = i; j < W; j++) p = p ^ int'(g[j]);
      r = r + (p << i);
    end
    return r;
  endfunction

  // One clock edge with the given incr; check latency, value and single-bit step.
  task automatic step(input logic b, input string tag);
    @(negedge clk);
    incr = b;
    #1;
    chk({tag, "_nocomb"}, dataOut, prev);
    @(posedge clk);
    #1;
    if (b) cnt = (cnt + 1) % MOD;
    chk({tag, "_val"}, dataOut, to_gray(cnt));
    chk({tag, "_ham"}, $countones(dataOut ^ prev), b ? 1 : 0);
    chk({tag, "_dec"}, from_gray(dataOut), cnt);
    prev = dataOut;
  endtask

  task automatic async_pulse(input string tag);
    @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    chk({tag, "_imm"}, dataOut, 0);
    cnt = 0;
    prev = '0;
    @(negedge clk);
    incr = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_hold"}, dataOut, 0);
    @(negedge clk);
    incr = 1'b0;
    rstN = 1'b1;
  endtask

  initial begin
    logic [W-1:0] seq [8];
    seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    prev = '0;
    #3;
    chk("reset_state", dataOut, 0);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < 5; i++) step(1'b0, "hold");

    for (int i = 0; i < 8; i++) begin
      step(1'b1, "seq");
      chk("seq_table", dataOut, seq[i]);
    end

    for (int i = 0; i < 16; i++) step(i[0] == 1'b0, "toggle");
    chk("toggle_end", dataOut, 0);

    for (int i = 0; i < 3; i++) step(1'b1, "pre_async");
    async_pulse("async");

    for (int i = 0; i < 4; i++) step(1'b1, "to110");
    chk("at110", dataOut, 3'b110);
    async_pulse("midcount");
    step(1'b1, "after_rst");
    chk("after_rst_001", dataOut, 3'b001);

    for (int i = 0; i < 1000; i++) step(1'($urandom_range(0, 1)), "rand");

    @(negedge clk);
    incr = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
